// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive constants, FSM state type and vote helper
package uart_pkg;

  localparam int OVS   = 16;
  localparam int NBITS = 10;
  localparam int SMP0  = 7;
  localparam int SMP1  = 8;
  localparam int SMP2  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CHECK,
    ST_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer; resets to the idle-high line level
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - UART receive control: start detect, 3-sample majority vote,
// shift-register sequencing and frame check.
module rx_ctrl #(
  parameter int OVS   = uart_pkg::OVS,
  parameter int NBITS = uart_pkg::NBITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             baud_tick,
  input  logic [NBITS-1:0] sipo_data,
  output logic             rx_bit,
  output logic             shift,
  output logic             sample_done,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(NBITS + 1);

  logic rxs;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (rxs)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          s0_q, s0_d, s1_q, s1_d;
  logic          rx_bit_q, rx_bit_d;
  logic          sd_q, sd_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          shift_q, shift_d;
  logic          busy_q, busy_d;

  logic in_bit, wrap, at_vote, vote;

  assign in_bit  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  assign wrap    = (tick_q == TW'(OVS - 1));
  assign at_vote = in_bit && baud_tick && (tick_q == TW'(SMP2));
  // third sample is taken straight from rxs so the vote lands on the capture edge
  assign vote    = maj3(s0_q, s1_q, rxs);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    rx_bit_d = rx_bit_q;
    sd_d     = 1'b0;
    data_d   = data_q;
    ferr_d   = ferr_q;
    valid_d  = 1'b0;

    if (in_bit && baud_tick) begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
      if (tick_q == TW'(SMP0)) s0_d = rxs;
      if (tick_q == TW'(SMP1)) s1_d = rxs;
    end

    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rxs) begin
          state_d = ST_START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START, ST_DATA, ST_STOP: begin
        if (at_vote) begin
          if (state_q == ST_START && vote) begin
            state_d = ST_IDLE;
          end else begin
            rx_bit_d = vote;
            sd_d     = 1'b1;
            bit_d    = bit_q + 1'b1;
          end
        end else if (state_q == ST_STOP) begin
          // leave mid stop bit so the next start edge is never missed
          if (sd_q) state_d = ST_CHECK;
        end else if (baud_tick && wrap) begin
          state_d = (state_q == ST_START || bit_q != BW'(NBITS - 1)) ? ST_DATA : ST_STOP;
        end
      end
      ST_CHECK: begin
        data_d  = sipo_data[NBITS-2:1];
        ferr_d  = ~sipo_data[NBITS-1] | sipo_data[0];
        valid_d = 1'b1;
        state_d = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    shift_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      rx_bit_q <= 1'b1;
      sd_q     <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      rx_bit_q <= rx_bit_d;
      sd_q     <= sd_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
    end
  end

  assign rx_bit      = rx_bit_q;
  assign shift       = shift_q;
  assign sample_done = sd_q;
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - randomized self-checking bench for rx_ctrl with a
// frame-level reference model and a behavioural shift register.
module tb_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_in;
  logic       baud_tick;
  logic [9:0] sipo_data;
  logic       rx_bit, shift, sample_done, data_valid, frame_err, busy;
  logic [7:0] data_out;

  int vectors = 0;
  int miscompares = 0;
  int sd_cnt = 0;
  int busy_cnt = 0;
  logic [8:0] vq[$];

  always #5 clk = ~clk;

  rx_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .baud_tick   (baud_tick),
    .sipo_data   (sipo_data),
    .rx_bit      (rx_bit),
    .shift       (shift),
    .sample_done (sample_done),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // stand-in for rx_sipo: first received bit ends up in bit 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sipo_data <= '0;
    else if (shift && sample_done) sipo_data <= {rx_bit, sipo_data[9:1]};
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_done) sd_cnt++;
      if (data_valid) vq.push_back({frame_err, data_out});
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic v, input int gpos);
    for (int t = 0; t < 16; t++) begin
      rx_in = (t == gpos) ? ~v : v;
      wait_tick(1);
    end
  endtask

  // gbit selects a data bit that gets a one-tick inversion at tick gpos
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int gbit, input int gpos);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == gbit) ? gpos : -1);
    drive_bit(stopv, -1);
  endtask

  // reference: the byte sent and an error exactly when the stop bit was low
  task automatic check_frame(input string tag, input logic [7:0] b, input logic stopv, input int sd0);
    logic [8:0] v;
    chk({tag, "_nvalid"}, vq.size(), 1);
    if (vq.size() > 0) begin
      v = vq.pop_front();
      chk({tag, "_data"}, v[7:0], b);
      chk({tag, "_ferr"}, v[8], !stopv);
    end
    chk({tag, "_sdcnt"}, sd_cnt - sd0, 10);
    vq.delete();
  endtask

  initial begin
    int sd0, b0, gbit, gpos, gap;
    logic [7:0] b;
    logic stopv;

    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_bit", rx_bit, 1);
    chk("rst_shift", shift, 0);
    chk("rst_sample_done", sample_done, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 8'h00);
    reset_n = 1'b1;
    wait_tick(4);

    sd0 = sd_cnt;
    send_frame(8'hA5, 1'b1, -1, 0);
    check_frame("a5", 8'hA5, 1'b1, sd0);
    wait_tick(8);

    sd0 = sd_cnt;
    b0  = busy_cnt;
    rx_in = 1'b0;
    wait_tick(4);
    rx_in = 1'b1;
    wait_tick(20);
    chk("glitch_busy_seen", busy_cnt > b0, 1);
    chk("glitch_busy_drop", busy, 0);
    chk("glitch_sd", sd_cnt - sd0, 0);
    chk("glitch_valid", vq.size(), 0);

    sd0 = sd_cnt;
    send_frame(8'h3C, 1'b0, -1, 0);
    wait_tick(32);
    chk("break_busy", busy, 1);
    check_frame("3c", 8'h3C, 1'b0, sd0);
    rx_in = 1'b1;
    wait_tick(24);
    chk("break_exit", busy, 0);
    chk("break_no_frame", vq.size(), 0);
    chk("break_sd", sd_cnt - sd0, 10);

    sd0 = sd_cnt;
    send_frame(8'hFF, 1'b1, 3, 8);
    check_frame("ff_vote", 8'hFF, 1'b1, sd0);
    wait_tick(8);

    sd0 = sd_cnt;
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    wait_tick(4);
    chk("b2b_nvalid", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_first", vq[0], {1'b0, 8'h00});
      chk("b2b_second", vq[1], {1'b0, 8'hFF});
    end
    chk("b2b_sd", sd_cnt - sd0, 20);
    vq.delete();

    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    wait_tick(8);
    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_bit", rx_bit, 1);
    chk("midrst_shift", shift, 0);
    vq.delete();
    reset_n = 1'b1;
    wait_tick(40);
    chk("midrst_no_valid", vq.size(), 0);
    sd0 = sd_cnt;
    send_frame(8'h5A, 1'b1, -1, 0);
    check_frame("5a", 8'h5A, 1'b1, sd0);
    wait_tick(4);

    for (int n = 0; n < 16; n++) begin
      b     = 8'($urandom);
      stopv = ($urandom_range(0, 4) != 0);
      gbit  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      gpos  = int'($urandom_range(7, 9));
      sd0   = sd_cnt;
      send_frame(b, stopv, gbit, gpos);
      check_frame($sformatf("rnd%0d", n), b, stopv, sd0);
      if (stopv) begin
        gap = int'($urandom_range(0, 20));
        if (gap > 0) wait_tick(gap);
      end else begin
        gap = int'($urandom_range(0, 20));
        if (gap > 0) wait_tick(gap);
        rx_in = 1'b1;
        wait_tick(2 + int'($urandom_range(0, 6)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 Parameter OVS, default 16, SHALL set the baud ticks per bit.
REQ-002 Parameter NBITS, default 10, SHALL set the frame length: start + 8 data + stop.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_in  input  1  raw asynchronous serial line; idle level is high.
REQ-006 baud_tick  input  1  one-clk strobe at OVS x baud rate.
REQ-007 sipo_data  input  10  parallel word from the shift register; LSB is the first bit received.
REQ-008 rx_bit  output  1  voted bit value presented to the shift register.
REQ-009 shift  output  1  shift enable to the shift register; high in START, DATA and STOP.
REQ-010 sample_done  output  1  one-clk strobe; the shift register loads rx_bit on it.
REQ-011 data_out  output  8  received byte, held until the next frame completes.
REQ-012 data_valid  output  1  one-clk pulse when data_out/frame_err update.
REQ-013 frame_err  output  1  set when start!=0 or stop!=1; valid with data_valid.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx_in SHALL pass a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, CHECK, BREAK.
REQ-017 IDLE: on baud_tick with rxs=0, the FSM SHALL go to START with tick_cnt=0 and bit_cnt=0.
REQ-018 tick_cnt (0..OVS-1) SHALL increment on each baud_tick in START/DATA/STOP and wrap OVS-1 -> 0.
REQ-019 The FSM SHALL capture rxs at tick_cnt 7, 8 and 9; rx_bit SHALL be the majority of the three samples.
REQ-020 sample_done SHALL pulse in the clk after the tick-9 capture in START, DATA and STOP; bit_cnt SHALL increment on that pulse.
REQ-021 START: a voted value of 1 is a false start; the FSM SHALL return to IDLE with no sample_done and no data_valid.
REQ-022 START: a voted value of 0 SHALL emit sample_done; the FSM SHALL go to DATA at the tick_cnt wrap.
REQ-023 DATA: after the 8th data sample_done (bit_cnt=9) the FSM SHALL go to STOP at the tick_cnt wrap.
REQ-024 STOP: the FSM SHALL go to CHECK in the clk after the stop sample_done; it SHALL not wait for the remainder of the bit.
REQ-025 CHECK (one clk): data_out <= sipo_data[8:1]; frame_err <= ~sipo_data[9] | sipo_data[0]; data_valid=1.
REQ-026 From CHECK the FSM SHALL go to IDLE if rxs=1, else to BREAK.
REQ-027 BREAK SHALL hold until rxs=1, then go to IDLE, so a low line is never re-detected as a start.
REQ-028 A new frame SHALL be accepted on the first baud_tick with rxs=0 in IDLE, giving back-to-back operation.
REQ-029 Total sample_done pulses per valid frame SHALL equal NBITS (10).
REQ-030 If baud_tick and the CHECK clk coincide, the tick SHALL be ignored.

Reset
REQ-031 On reset_n=0 the state SHALL be IDLE and the counters and vote samples SHALL be 0.
REQ-032 On reset_n=0, shift, sample_done, data_valid, frame_err and busy SHALL be 0, data_out SHALL be 0x00, and rx_bit SHALL be 1.
REQ-033 The synchronizer flops SHALL reset to 1 (idle line).
REQ-034 Reset mid-frame SHALL abort the frame with no data_valid; reception SHALL resume at the next falling edge after release.

Structure
REQ-035 A shared package uart_pkg SHALL hold the state enum, OVS, NBITS and the sample indices 7/8/9.
REQ-036 The synchronizer SHALL be the sub-module sync_2ff; the FSM, counters and vote SHALL live in rx_ctrl.
REQ-037 rx_ctrl SHALL drive rx_sipo through shift, sample_done and rx_bit, and read its data_out as sipo_data.

Verification
REQ-038 Frame 0xA5 at 16x ticks -> 10 sample_done pulses, data_out=0xA5, frame_err=0, one data_valid.
REQ-039 Low glitch of 4 ticks in IDLE -> return to IDLE, no sample_done, no data_valid, busy drops.
REQ-040 Frame 0x3C with stop bit=0 held low -> data_out=0x3C, frame_err=1, FSM in BREAK until line high, no spurious frame.
REQ-041 One-tick inversion at tick 8 of data bit 3 of 0xFF -> majority vote gives data_out=0xFF.
REQ-042 Frames 0x00 then 0xFF back-to-back with no idle -> two data_valid pulses, correct bytes.
REQ-043 reset_n low during data bit 4, released, then frame 0x5A -> no data_valid for the aborted frame, then 0x5A received.
